// File: rtl/vx_mem_responder.sv
// vx_mem_responder: behavioural memory slave with a fixed-latency read pipeline
// and a credit-bounded, in-order response FIFO.
// Optional build macro: VX_MEM_RSP_WR_ACK_EN -- writes also return a response
// (tag echoed, data zero) and consume a credit, ordered with reads.
module vx_mem_responder #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 26,
  parameter int TAG_WIDTH       = 8,
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 4,
  parameter int RSP_QUEUE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_byteen,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  input  logic                    rsp_ready,
  output logic [31:0]             wr_count,
  output logic [31:0]             rd_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LINES = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(RSP_QUEUE_DEPTH);
  localparam int CRD_W = $clog2(RSP_QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  logic [DATA_WIDTH-1:0] mem [LINES];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept, accept_wr, accept_rd;
  logic                  in_valid, push_valid, pop;
  entry_t                in_entry, push_entry;

  // Upper line-address bits alias onto the same storage.
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign idx         = req_addr[DEPTH_LOG2-1:0];

  assign accept    = req_valid & req_ready;
  assign accept_wr = accept & req_rw;
  assign accept_rd = accept & ~req_rw;

`ifdef VX_MEM_RSP_WR_ACK_EN
  assign in_valid      = accept;
  assign in_entry.data = req_rw ? '0 : mem[idx];
`else
  assign in_valid      = accept_rd;
  assign in_entry.data = mem[idx];
`endif
  assign in_entry.tag  = req_tag;

  // Byte-masked line write at the accepting edge.
  // NOTE: storage arrays carry no reset; contents survive reset and only control state is cleared.
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_byteen[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end

  // The FIFO slot is the final pipeline stage, so LATENCY-1 registered stages
  // sit in front of it and a read reaches rsp_valid exactly LATENCY cycles later.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = in_valid;
    assign push_entry = in_entry;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;
    logic [STAGES-1:0] valid_q, valid_d;
    entry_t            entry_q [STAGES];
    entry_t            entry_d [STAGES];

    // Shift the stage contents one step per cycle.
    always_comb begin
      valid_d[0] = in_valid;
      entry_d[0] = in_entry;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        entry_d[i] = entry_q[i-1];
      end
    end

    // Stage valids are cleared by reset, dropping in-flight reads.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!reset) valid_q <= '0;
      else        valid_q <= valid_d;
    end

    // Stage payloads need no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
      entry_q <= entry_d;
    end

    assign push_valid = valid_q[STAGES-1];
    assign push_entry = entry_q[STAGES-1];
  end

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CRD_W-1:0] credit_q, credit_d;
  logic [31:0]    wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic           fifo_empty, fifo_full;
  entry_t         fifo_q [RSP_QUEUE_DEPTH];
  entry_t         head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];

  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_tag   = rsp_valid ? head.tag  : '0;
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = reset && (credit_q < CRD_W'(RSP_QUEUE_DEPTH));
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

  // Next-state for pointers, credits and saturating counters.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push_valid);
    rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
    credit_d   = credit_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (in_valid && !pop)      credit_d = credit_q + 1'b1;
    else if (!in_valid && pop) credit_d = credit_q - 1'b1;
    if (accept_wr && wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
    if (accept_rd && rd_count_q != '1) rd_count_d = rd_count_q + 32'd1;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      credit_q   <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      credit_q   <= credit_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  // Response FIFO storage write.
  always_ff @(posedge clk) begin
    if (push_valid) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end

  // Credits make overflow impossible; a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push_valid && fifo_full));

endmodule

// File: tb/tb_vx_mem_responder.sv
// Scoreboard bench for vx_mem_responder: expectations are queued at request
// acceptance and compared in order as responses are popped.
module tb_vx_mem_responder;

  localparam int DW    = 512;
  localparam int AW    = 26;
  localparam int TW    = 8;
  localparam int DL2   = 10;
  localparam int LAT   = 4;
  localparam int QD    = 4;
  localparam int BE    = DW / 8;
  localparam int LINES = 1 << DL2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_rw, req_ready;
  logic [AW-1:0] req_addr;
  logic [BE-1:0] req_byteen;
  logic [DW-1:0] req_data, rsp_data;
  logic [TW-1:0] req_tag, rsp_tag;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   wr_count, rd_count;

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .DEPTH_LOG2(DL2), .LATENCY(LAT), .RSP_QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [int];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Response monitor: compare every popped response with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", DW'(1), DW'(0));
      end else begin
        e = sb.pop_front();
        check("rsp_tag", DW'(rsp_tag), DW'(e.tag));
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  // Drive one request and hold it until accepted; queues the expected response.
  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [BE-1:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] t, output int acc);
    logic [DW-1:0] line;
    exp_t          e;
    int            key;
    req_valid  = 1'b1;
    req_rw     = rw;
    req_addr   = addr;
    req_byteen = be;
    req_data   = data;
    req_tag    = t;
    acc        = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        key = int'(addr) & (LINES - 1);
        if (rw) begin
          line = model.exists(key) ? model[key] : '0;
          for (int b = 0; b < BE; b++) if (be[b]) line[b*8 +: 8] = data[b*8 +: 8];
          model[key] = line;
          exp_wr++;
`ifdef VX_MEM_RSP_WR_ACK_EN
          e.tag  = t;
          e.data = '0;
          sb.push_back(e);
`endif
        end else begin
          e.tag  = t;
          e.data = model[key];
          sb.push_back(e);
          exp_rd++;
        end
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) check("req_timeout", DW'(0), DW'(1));
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", DW'(sb.size()), DW'(0));
  endtask

  // Hold a read for six cycles, advancing the tag on each accept; returns accept count.
  task automatic burst_reads(input logic [TW-1:0] base, output int acc_n);
    exp_t e;
    acc_n      = 0;
    req_valid  = 1'b1;
    req_rw     = 1'b0;
    req_addr   = AW'('h10);
    req_byteen = '0;
    req_data   = '0;
    req_tag    = base;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.tag  = req_tag;
        e.data = model[16];
        sb.push_back(e);
        exp_rd++;
        acc_n++;
      end
      @(posedge clk); #1;
      req_tag = base + TW'(acc_n);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, n, seen0;
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_byteen = '0;
    req_data   = '0;
    req_tag    = '0;
    rsp_ready  = 1'b1;

    // Reset held with a pending request.
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", DW'(req_ready), DW'(0));
      check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("rst_rsp_tag", DW'(rsp_tag), DW'(0));
      check("rst_rsp_data", rsp_data, '0);
      check("rst_wr_count", DW'(wr_count), DW'(0));
      check("rst_rd_count", DW'(rd_count), DW'(0));
    end
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rel_req_ready", DW'(req_ready), DW'(1));
    @(posedge clk); #1;

    // Write then read back-to-back, with minimum-latency measurement.
    issue(1'b1, AW'('h10), '1, DW'('h2000f133), TW'(0), a);
    issue(1'b0, AW'('h10), '0, '0, TW'('h5), a);
    idle();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_tag == TW'('h5)) begin
        n = 1;
        break;
      end
    end
    check("rd_latency_seen", DW'(n), DW'(1));
    check("rd_latency", DW'(cyc - a), DW'(LAT));
    drain();
    check("wr_count_1", DW'(wr_count), DW'(exp_wr));
    check("rd_count_1", DW'(rd_count), DW'(exp_rd));

    // Byte enables.
    issue(1'b1, AW'(3), '1, DW'('hAABBCCDD), TW'(1), a);
    issue(1'b1, AW'(3), BE'(2'b11), DW'('h11223344), TW'(2), a);
    issue(1'b0, AW'(3), '0, '0, TW'('h33), a);
    idle();
    drain();

    // Address aliasing on the upper bits.
    issue(1'b1, AW'('h400), '1, DW'(1), TW'(3), a);
    issue(1'b0, AW'('h000), '0, '0, TW'('h44), a);
    idle();
    drain();

    // Back-pressure: credits stop acceptance at the queue depth.
    rsp_ready = 1'b0;
    burst_reads(TW'('h20), n);
    check("bp_accepted", DW'(n), DW'(QD));
    repeat (6) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_ready_low", DW'(req_ready), DW'(0));
    check("bp_rsp_valid", DW'(rsp_valid), DW'(1));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_pop", DW'(req_ready), DW'(0));
    @(negedge clk);
    check("bp_ready_after_pop", DW'(req_ready), DW'(1));
    drain();
    check("rd_count_bp", DW'(rd_count), DW'(exp_rd));

    // Reset with three reads in flight.
    issue(1'b0, AW'('h10), '0, '0, TW'('h60), a);
    issue(1'b0, AW'('h10), '0, '0, TW'('h61), a);
    issue(1'b0, AW'('h10), '0, '0, TW'('h62), a);
    idle();
    reset = 1'b0;
    sb.delete();
    exp_wr = 0;
    exp_rd = 0;
    seen0  = rsp_seen;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst2_wr_count", DW'(wr_count), DW'(0));
    check("rst2_rd_count", DW'(rd_count), DW'(0));
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("rst2_no_rsp", DW'(rsp_seen), DW'(seen0));
    rsp_ready = 1'b0;
    burst_reads(TW'('h70), n);
    check("rst2_accepted", DW'(n), DW'(QD));
    rsp_ready = 1'b1;
    drain();
    check("rst2_rd_count_4", DW'(rd_count), DW'(exp_rd));

`ifdef VX_MEM_RSP_WR_ACK_EN
    // Write acknowledge: tag echoed with zero data after the read latency.
    issue(1'b1, AW'('h20), '1, DW'('hdead), TW'('h9), a);
    idle();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = 1;
        break;
      end
    end
    check("wack_seen", DW'(n), DW'(1));
    check("wack_latency", DW'(cyc - a), DW'(LAT));
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
